// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C configuration
//                sequencer: FSM state encoding, ROM entry layout, opcodes
//                and a ceiling-log2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // ROM entry opcodes
    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_DELAY = 8'h01;
    localparam logic [7:0] OP_END   = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_WAIT_ROM  = 4'd2,
        S_DECODE    = 4'd3,
        S_ISSUE     = 4'd4,
        S_WAIT_RESP = 4'd5,
        S_DELAY     = 4'd6,
        S_NEXT      = 4'd7,
        S_DONE      = 4'd8,
        S_ERROR     = 4'd9
    } seq_state_t;

    // One 32-bit ROM line; 'reg' is a keyword, so the register field is reg_addr
    typedef struct packed {
        logic [7:0] op;
        logic       pad;
        logic [6:0] dev;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int mclog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_delay_timer
//  Description : Programmed-delay timer. A load captures a 24-bit unit count;
//                each unit lasts DLY_UNIT clocks via a free prescaler. The
//                expired output is high in the final cycle of the delay, so a
//                loaded count N keeps the caller waiting exactly N*DLY_UNIT
//                cycles. A count of 0 never expires (caller skips it).
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_delay_timer
    import i2c_pkg::*;
#(
    parameter int DLY_UNIT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] count,
    output logic        expired
);

    localparam int             PW         = (DLY_UNIT > 1) ? mclog2(DLY_UNIT) : 1;
    localparam logic [PW-1:0]  C_PRE_TOP  = PW'(DLY_UNIT - 1);

    logic [23:0]   r_units;
    logic [PW-1:0] r_pre;

    // Unit down-counter with prescaler; holds at zero once the delay ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_units <= '0;
            r_pre   <= '0;
        end else if (load) begin
            r_units <= count;
            r_pre   <= C_PRE_TOP;
        end else if (r_units != 24'd0) begin
            if (r_pre == '0) begin
                r_pre   <= C_PRE_TOP;
                r_units <= r_units - 24'd1;
            end else begin
                r_pre   <= r_pre - PW'(1);
            end
        end
    end

    assign expired = (r_units == 24'd1) && (r_pre == '0);

endmodule
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_cfg_sequencer
//  Description : Walks the I2C configuration ROM from line 0 and issues one
//                register-write command per WRITE entry to the I2C byte
//                master, honouring DELAY entries, an END marker and NACKs.
//                Build option: I2C_RETRY_EN - retry a NACKed WRITE up to
//                MAX_RETRY times before flagging an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_cfg_sequencer
    import i2c_pkg::*;
#(
    parameter int LINES     = 16,
    parameter int DW        = 32,
    parameter int DLY_UNIT  = 1000,
    parameter int MAX_RETRY = 3,
    parameter int AW        = mclog2(LINES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [6:0]    cmd_dev,
    output logic [7:0]    cmd_reg,
    output logic [7:0]    cmd_data,
    input  logic          rsp_valid,
    input  logic          rsp_nack
);

    localparam logic [AW-1:0] C_LAST = AW'(LINES - 1);

    // The entry layout is fixed at 32 bits and retry counts cannot be negative
    if (DW != 32 || MAX_RETRY < 0) begin : g_bad_cfg
        $error("i2c_cfg_sequencer: DW must be 32 and MAX_RETRY >= 0");
    end

    seq_state_t  r_state;
    cfg_entry_t  r_entry;
    logic [31:0] w_raw;
    logic [23:0] w_count;
    logic        w_load;
    logic        w_expired;

    assign w_raw   = r_entry;
    assign w_count = w_raw[23:0];
    assign w_load  = (r_state == S_DECODE) && (r_entry.op == OP_DELAY);

`ifdef I2C_RETRY_EN
    localparam int            RW          = (MAX_RETRY > 0) ? mclog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRY);
    logic [RW-1:0] r_retry;
`endif

    i2c_delay_timer #(
        .DLY_UNIT (DLY_UNIT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .count   (w_count),
        .expired (w_expired)
    );

    // Sequencer FSM; every output is registered and updated on state entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_entry   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= '0;
            rom_addr  <= '0;
            cmd_valid <= 1'b0;
            cmd_dev   <= '0;
            cmd_reg   <= '0;
            cmd_data  <= '0;
`ifdef I2C_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        rom_addr <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT_ROM;
                end
                S_WAIT_ROM: begin
                    r_entry <= rom_data;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
`ifdef I2C_RETRY_EN
                    r_retry <= '0;
`endif
                    case (r_entry.op)
                        OP_WRITE: begin
                            cmd_dev   <= r_entry.dev;
                            cmd_reg   <= r_entry.reg_addr;
                            cmd_data  <= r_entry.data;
                            cmd_valid <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
                        OP_DELAY: begin
                            r_state <= (w_count == 24'd0) ? S_NEXT : S_DELAY;
                        end
                        OP_END: begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end
                        default: begin
                            error    <= 1'b1;
                            err_addr <= rom_addr;
                            busy     <= 1'b0;
                            r_state  <= S_ERROR;
                        end
                    endcase
                end
                S_ISSUE: begin
                    // Fields stay frozen until the master takes the command
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        r_state   <= S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    if (rsp_valid) begin
                        if (!rsp_nack) begin
                            r_state <= S_NEXT;
                        end
`ifdef I2C_RETRY_EN
                        else if (r_retry < C_MAX_RETRY) begin
                            r_retry   <= r_retry + RW'(1);
                            cmd_valid <= 1'b1;
                            r_state   <= S_ISSUE;
                        end
`endif
                        else begin
                            error    <= 1'b1;
                            err_addr <= rom_addr;
                            busy     <= 1'b0;
                            r_state  <= S_ERROR;
                        end
                    end
                end
                S_DELAY: begin
                    if (w_expired) r_state <= S_NEXT;
                end
                S_NEXT: begin
                    // The last line ends the sequence even without an END entry
                    if (rom_addr == C_LAST) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        rom_addr <= rom_addr + AW'(1);
                        r_state  <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_cfg_sequencer
//  Description : Scoreboard bench for i2c_cfg_sequencer with a registered ROM
//                model and an I2C master responder. Honours I2C_RETRY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_sequencer;

    localparam int LINES    = 16;
    localparam int AW       = 4;
    localparam int DLY_UNIT = 4;
    localparam int K_CMD    = 0;
    localparam int K_DONE   = 1;
    localparam int K_ERR    = 2;

    typedef struct {
        int          kind;
        logic [22:0] fields;
        logic [AW-1:0] line;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_addr;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [6:0]    cmd_dev;
    logic [7:0]    cmd_reg;
    logic [7:0]    cmd_data;
    logic          rsp_valid;
    logic          rsp_nack;

    logic [31:0] rom [LINES];
    exp_t        exp_q[$];
    bit          nack_q[$];
    logic        resp_en;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          t_addr [LINES];

    i2c_cfg_sequencer #(
        .LINES     (LINES),
        .DW        (32),
        .DLY_UNIT  (DLY_UNIT),
        .MAX_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_addr  (err_addr),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dev   (cmd_dev),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_nack  (rsp_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    function automatic logic [31:0] ent_w(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        return {8'h00, 1'b0, d, r, v};
    endfunction

    function automatic logic [31:0] ent_d(input logic [23:0] n);
        return {8'h01, n};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic push_cmd(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
        exp_t e;
        e.kind = K_CMD; e.fields = {d, r, v}; e.line = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_evt(input int k, input logic [AW-1:0] ln);
        exp_t e;
        e.kind = k; e.fields = '0; e.line = ln;
        exp_q.push_back(e);
    endtask

    task automatic take(input int k, input logic [22:0] f, input logic [AW-1:0] ln);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, required nothing", k);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == K_CMD && k == K_CMD) chk("cmd_fields", 32'(f), 32'(e.fields));
            if (e.kind == K_ERR && k == K_ERR) chk("err_addr", 32'(ln), 32'(e.line));
            if (k == K_DONE) chk("busy_at_done", 32'(busy), 32'd0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        logic          prev_err;
        logic [AW-1:0] prev_addr;
        prev_err  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rom_addr !== prev_addr) t_addr[rom_addr] = cyc;
            prev_addr = rom_addr;
            if (cmd_valid && cmd_ready) take(K_CMD, {cmd_dev, cmd_reg, cmd_data}, '0);
            if (done) take(K_DONE, '0, '0);
            if (error && !prev_err) take(K_ERR, '0, err_addr);
            prev_err = error;
        end
    end

    // Master responder: answers two cycles after each accepted command
    initial begin
        int wait_n;
        wait_n    = -1;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            if (wait_n == 0) begin
                rsp_valid = 1'b1;
                rsp_nack  = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                wait_n    = -1;
            end else if (wait_n > 0) begin
                wait_n--;
            end
            if (cmd_valid && cmd_ready && resp_en) wait_n = 1;
        end
    end

    task automatic rom_fill_end();
        for (int i = 0; i < LINES; i++) rom[i] = 32'hFF00_0000;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rst_n     = 1'b0;
        start     = 1'b0;
        cmd_ready = 1'b1;
        resp_en   = 1'b1;
        rom_fill_end();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);

        // Two writes then END; a second start mid-sequence must be ignored
        rom_fill_end();
        rom[0] = ent_w(7'h39, 8'h41, 8'h10);
        rom[1] = ent_w(7'h39, 8'h98, 8'h03);
        push_cmd(7'h39, 8'h41, 8'h10);
        push_cmd(7'h39, 8'h98, 8'h03);
        push_evt(K_DONE, '0);
        pulse_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        repeat (5) @(posedge clk);
        pulse_start();
        wait_idle("basic", 200);
        chk("basic_error", 32'(error), 32'd0);

        // Master stalls for 5 cycles: command must stay put
        rom_fill_end();
        rom[0] = ent_w(7'h50, 8'h01, 8'hAA);
        push_cmd(7'h50, 8'h01, 8'hAA);
        push_evt(K_DONE, '0);
        @(posedge clk); #1 cmd_ready = 1'b0;
        pulse_start();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (cmd_valid) found = 1;
        end
        chk("hold_seen", 32'(found), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_fields", {9'd0, cmd_dev, cmd_reg, cmd_data}, {9'd0, 7'h50, 8'h01, 8'hAA});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 cmd_ready = 1'b1;
        wait_idle("hold", 200);

        // DELAY 2 adds 2*DLY_UNIT cycles; DELAY 0 adds none
        rom_fill_end();
        rom[0] = ent_w(7'h10, 8'h00, 8'h01);
        rom[1] = ent_d(24'd2);
        rom[2] = ent_w(7'h10, 8'h00, 8'h02);
        rom[3] = ent_d(24'd0);
        rom[4] = ent_w(7'h10, 8'h00, 8'h03);
        push_cmd(7'h10, 8'h00, 8'h01);
        push_cmd(7'h10, 8'h00, 8'h02);
        push_cmd(7'h10, 8'h00, 8'h03);
        push_evt(K_DONE, '0);
        pulse_start();
        wait_idle("delay", 300);
        chk("delay2_gap", 32'(t_addr[2] - t_addr[1]), 32'd12);
        chk("delay0_gap", 32'(t_addr[4] - t_addr[3]), 32'd4);

        // NACK on line 1
        rom_fill_end();
        rom[0] = ent_w(7'h20, 8'h01, 8'h01);
        rom[1] = ent_w(7'h20, 8'h02, 8'h02);
        rom[2] = ent_w(7'h20, 8'h03, 8'h03);
        push_cmd(7'h20, 8'h01, 8'h01);
        push_cmd(7'h20, 8'h02, 8'h02);
        nack_q.push_back(1'b0);
        nack_q.push_back(1'b1);
`ifdef I2C_RETRY_EN
        nack_q.push_back(1'b1);
        push_cmd(7'h20, 8'h02, 8'h02);
        push_cmd(7'h20, 8'h02, 8'h02);
        push_cmd(7'h20, 8'h03, 8'h03);
        push_evt(K_DONE, '0);
        pulse_start();
        wait_idle("nack_retry", 300);
        chk("nack_retry_error", 32'(error), 32'd0);
`else
        push_evt(K_ERR, 4'd1);
        pulse_start();
        wait_idle("nack", 300);
        chk("nack_error_sticky", 32'(error), 32'd1);
        chk("nack_err_addr", 32'(err_addr), 32'd1);
`endif
        nack_q.delete();

        // Bad opcode at line 2; the new start clears any old error
        rom_fill_end();
        rom[0] = ent_w(7'h30, 8'h01, 8'h01);
        rom[1] = ent_w(7'h30, 8'h02, 8'h02);
        rom[2] = 32'h7E30_0303;
        push_cmd(7'h30, 8'h01, 8'h01);
        push_cmd(7'h30, 8'h02, 8'h02);
        push_evt(K_ERR, 4'd2);
        pulse_start();
        @(negedge clk);
        chk("start_clears_error", 32'(error), 32'd0);
        wait_idle("badop", 300);
        chk("badop_error", 32'(error), 32'd1);
        chk("badop_err_addr", 32'(err_addr), 32'd2);

        // Sixteen writes, no END: finishes after the last line
        for (int i = 0; i < LINES; i++) begin
            rom[i] = ent_w(7'h40, 8'(i), 8'(8'hC0 + i));
            push_cmd(7'h40, 8'(i), 8'(8'hC0 + i));
        end
        push_evt(K_DONE, '0);
        pulse_start();
        wait_idle("full_rom", 600);
        chk("full_rom_addr", 32'(rom_addr), 32'd15);

        // Reset while waiting for the response
        rom_fill_end();
        rom[0] = ent_w(7'h60, 8'h01, 8'h01);
        push_cmd(7'h60, 8'h01, 8'h01);
        resp_en = 1'b0;
        pulse_start();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) found = 1;
        end
        chk("rstmid_handshake", 32'(found), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstmid_stays_idle", 32'(busy), 32'd0);
        chk("rstmid_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
